// File: rtl/btn_ctrl_pkg.sv
// btn_ctrl_pkg: shared state encoding, level constants and ms-to-cycles helper
package btn_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;
  localparam logic PRESSED  = 1'b1;
  localparam logic RELEASED = 1'b0;
  function automatic int ms_to_cycles(input int hz, input int ms);
    return hz / 1000 * ms;
  endfunction
endpackage

// File: rtl/btn_sync.sv
// btn_sync: polarity normalisation to active-high plus 2-FF synchroniser
module btn_sync
  import btn_ctrl_pkg::*;
#(
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic s2
);
  logic s1_q, s1_d, s2_q, s2_d;
  always_comb begin
    s1_d = (BTN_ACTIVE_LOW != 0) ? ~btn_in : btn_in;
    s2_d = s1_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= RELEASED;
      s2_q <= RELEASED;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
  assign s2 = s2_q;
endmodule

// File: rtl/btn_debounce_ctrl.sv
// btn_debounce_ctrl: button debouncer with press/release pulses, toggle, press counter; LONG_PRESS_EN adds long_press
module btn_debounce_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_PRESS_MS  = 1000,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       toggle_out,
  output logic [7:0] press_count,
  output logic       long_press
);
  localparam int DB_CYCLES = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int LP_CYCLES = ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
  localparam int CW = $clog2(((DB_CYCLES > LP_CYCLES) ? DB_CYCLES : LP_CYCLES) + 1);
  if (DB_CYCLES < 1 || LP_CYCLES < 1) begin : g_bad_cfg
    $error("btn_debounce_ctrl: DB_CYCLES and LP_CYCLES must be >= 1");
  end
  logic s2;
  btn_sync #(.BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .btn_in(btn_in),
    .s2    (s2)
  );
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, release_q, release_d, toggle_q, toggle_d;
  logic [7:0] count_q, count_d;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
    count_d   = count_q;
    case (state_q)
      IDLE: if (s2 == PRESSED) begin
        state_d = PRESS_WAIT;
        cnt_d   = '0;
      end
      PRESS_WAIT: if (s2 == RELEASED) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        state_d  = HELD;
        press_d  = 1'b1;
        level_d  = PRESSED;
        toggle_d = ~toggle_q;
        count_d  = count_q + 8'd1;
      end else cnt_d = cnt_q + CW'(1);
      HELD: if (s2 == RELEASED) begin
        state_d = RELEASE_WAIT;
        cnt_d   = '0;
      end
      RELEASE_WAIT: if (s2 == PRESSED) state_d = HELD;
      else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        state_d   = IDLE;
        release_d = 1'b1;
        level_d   = RELEASED;
      end else cnt_d = cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      count_q   <= count_d;
    end
  end
  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign toggle_out    = toggle_q;
  assign press_count   = count_q;
`ifdef LONG_PRESS_EN
  logic [CW-1:0] hold_q, hold_d;
  logic long_q, long_d;
  always_comb begin
    hold_d = (state_q == IDLE) ? '0 : hold_q;
    long_d = 1'b0;
    if (state_q == HELD && s2 == PRESSED && hold_q != CW'(LP_CYCLES)) begin
      hold_d = hold_q + CW'(1);
      long_d = (hold_q == CW'(LP_CYCLES - 1));
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end
  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif
endmodule
